// File: rtl/cpu_exec_ctrl_if.sv
// Button, switch, halt and CPU-control bundle for cpu_exec_ctrl.
// The master side drives the inputs and the slave side is the sequencer.
// Build macro BREAKPOINT_EN adds the pc/bp_addr/bp_valid inputs and the bp_hit output.
interface cpu_exec_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             CLKButton;
    logic [1:0]       SW_mode;
    logic             halt;
    logic             cpu_ce;
    logic             cpu_rst_n;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] step_count;
`ifdef BREAKPOINT_EN
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             bp_hit;

    modport master (
        output CLKButton, SW_mode, halt, pc, bp_addr, bp_valid,
        input  cpu_ce, cpu_rst_n, ctrl_state, step_count, bp_hit
    );
    modport slave (
        input  CLKButton, SW_mode, halt, pc, bp_addr, bp_valid,
        output cpu_ce, cpu_rst_n, ctrl_state, step_count, bp_hit
    );
`else
    modport master (
        output CLKButton, SW_mode, halt,
        input  cpu_ce, cpu_rst_n, ctrl_state, step_count
    );
    modport slave (
        input  CLKButton, SW_mode, halt,
        output cpu_ce, cpu_rst_n, ctrl_state, step_count
    );
`endif
endinterface

// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer for the Basys3 single-cycle CPU.
// Debounces the step button, picks step/slow/fast/pause mode from the switches,
// produces a one-cycle clock enable for the datapath, sequences the CPU reset
// after board reset, stops on halt and counts issued enables.
// Build macro BREAKPOINT_EN adds a pc breakpoint that drops RUN back to single-step.
//
// state | meaning
// ------+-------------------------------------------------------------
// HOLD  | CPU held in reset for RST_HOLD cycles after board reset
// STEP  | one enable per debounced button press (mode 00), none in pause (11)
// RUN   | free-running enable every SLOW_DIV (01) or FAST_DIV (10) cycles
// HALT  | CPU executed halt; only a board reset leaves this state
module cpu_exec_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int SLOW_DIV   = 8,
    parameter int FAST_DIV   = 2,
    parameter int RST_HOLD   = 4,
    parameter int CNT_W      = 16
) (
    input  logic           BasysCLK,
    input  logic           RST_Button,
    cpu_exec_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_STEP = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int DIV_W   = $clog2(MAX_DIV + 1);
    localparam int HOLD_W  = $clog2(RST_HOLD + 1);

    localparam logic [DEB_W-1:0]  DEB_TC  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0]  SLOW_TC = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0]  FAST_TC = DIV_W'(FAST_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(RST_HOLD - 1);

    state_t            state;
    state_t            state_nxt;

    logic              btn_meta;
    logic              btn_sync;
    logic              btn_deb;
    logic              btn_deb_q;
    logic [DEB_W-1:0]  deb_cnt;
    logic              step_req;
    logic              req_q;

    logic [1:0]        sw_reg;
    logic [1:0]        mode_eff;
    logic              mode_chg;
    logic              run_mode;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_tc;
    logic              div_hit;

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;

    logic              ce_raw;
    logic [CNT_W-1:0]  step_count;

`ifdef BREAKPOINT_EN
    logic              bp_match;
    logic              bp_take;
    logic              bp_ovr;
    logic              bp_hit_q;
`endif

    // A raw switch value differing from the registered one is a mode change.
    assign mode_chg = (bus.SW_mode != sw_reg);

`ifdef BREAKPOINT_EN
    // After a breakpoint the sequencer behaves as if step mode were selected
    // until the operator moves the switches again.
    assign mode_eff = bp_ovr ? 2'b00 : sw_reg;
    assign bp_match = bus.bp_valid && (bus.pc == bus.bp_addr);
`else
    assign mode_eff = sw_reg;
`endif

    assign run_mode  = (mode_eff == 2'b01) || (mode_eff == 2'b10);
    assign div_tc    = (mode_eff == 2'b01) ? SLOW_TC : FAST_TC;
    assign div_hit   = (div_cnt == div_tc);
    assign hold_done = (hold_cnt == HOLD_TC);
    assign step_req  = btn_deb & ~btn_deb_q;

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= bus.CLKButton;
            btn_sync <= btn_meta;
        end
    end

    // Debouncer: the synced level must disagree with the debounced level for
    // DEB_CYCLES consecutive samples before it is accepted.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            deb_cnt   <= '0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
        end else begin
            btn_deb_q <= btn_deb;
            if (btn_sync == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_TC) begin
                btn_deb <= btn_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Registered switch mode.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            sw_reg <= 2'b00;
        end else begin
            sw_reg <= bus.SW_mode;
        end
    end

    // Step request register; requests outside single-step or during a mode
    // change are discarded rather than queued.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            req_q <= 1'b0;
        end else begin
            req_q <= step_req && (state == S_STEP) && (mode_eff == 2'b00) && !mode_chg;
        end
    end

    // Run divider: counts 0..DIV-1 in RUN, restarts on any mode change.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            div_cnt <= '0;
        end else if ((state != S_RUN) || mode_chg || div_hit) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // CPU reset hold timer, only advances while in HOLD.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            hold_cnt <= '0;
        end else if ((state == S_HOLD) && !hold_done) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            state <= S_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and enable; halt has priority over any pending pulse.
    always_comb begin
        state_nxt = state;
        ce_raw    = 1'b0;
`ifdef BREAKPOINT_EN
        bp_take   = 1'b0;
`endif
        case (state)
            S_HOLD: begin
                if (hold_done) begin
                    state_nxt = run_mode ? S_RUN : S_STEP;
                end
            end
            S_STEP: begin
                if (bus.halt) begin
                    state_nxt = S_HALT;
                end else if (run_mode) begin
                    state_nxt = S_RUN;
                end else if ((mode_eff == 2'b00) && req_q) begin
                    ce_raw = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.halt) begin
                    state_nxt = S_HALT;
`ifdef BREAKPOINT_EN
                end else if (bp_match) begin
                    state_nxt = S_STEP;
                    bp_take   = 1'b1;
`endif
                end else if (!run_mode) begin
                    state_nxt = S_STEP;
                end else if (div_hit) begin
                    ce_raw = 1'b1;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase
    end

    // Executed-instruction counter, wraps naturally at CNT_W bits.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            step_count <= '0;
        end else if (ce_raw) begin
            step_count <= step_count + CNT_W'(1);
        end
    end

`ifdef BREAKPOINT_EN
    // Breakpoint hit pulse and the step-mode override it leaves behind.
    always_ff @(posedge BasysCLK or negedge RST_Button) begin
        if (!RST_Button) begin
            bp_ovr   <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= bp_take;
            if (bp_take) begin
                bp_ovr <= 1'b1;
            end else if (mode_chg) begin
                bp_ovr <= 1'b0;
            end
        end
    end

    assign bus.bp_hit = bp_hit_q;
`endif

    assign bus.cpu_ce     = ce_raw;
    assign bus.cpu_rst_n  = (state != S_HOLD);
    assign bus.ctrl_state = state;
    assign bus.step_count = step_count;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl. Expected enables and states are scheduled
// per cycle from the behavioural rules (reset hold length, button latency,
// divider period, halt priority) and checked every cycle by one compare process.
module tb_cpu_exec_ctrl;

    localparam int DEB  = 16;
    localparam int SLOW = 8;
    localparam int FAST = 2;
    localparam int HOLD = 4;
    localparam int N    = 2048;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst_w4 = 1'b0;

    cpu_exec_ctrl_if #(.CNT_W(16)) bus ();
    cpu_exec_ctrl_if #(.CNT_W(4))  bus4 ();

    cpu_exec_ctrl #(
        .DEB_CYCLES(DEB), .SLOW_DIV(SLOW), .FAST_DIV(FAST), .RST_HOLD(HOLD), .CNT_W(16)
    ) u_dut (
        .BasysCLK(clk), .RST_Button(rst_n), .bus(bus)
    );

    cpu_exec_ctrl #(
        .DEB_CYCLES(DEB), .SLOW_DIV(SLOW), .FAST_DIV(1), .RST_HOLD(HOLD), .CNT_W(4)
    ) u_dut_w4 (
        .BasysCLK(clk), .RST_Button(rst_w4), .bus(bus4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   vectors     = 0;
    int   miscompares = 0;
    int   mcount      = 0;
    logic exp_ce [N];
    logic [1:0] exp_st [N];
`ifdef BREAKPOINT_EN
    logic exp_bp [N];
`endif
    logic w4_on   = 1'b0;
    int   w4_base = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_state(input int from, input logic [1:0] st);
        for (int i = from; i < N; i++) exp_st[i] = st;
    endtask

    task automatic clear_sched(input int from);
        for (int i = from; i < N; i++) begin
            exp_ce[i] = 1'b0;
`ifdef BREAKPOINT_EN
            exp_bp[i] = 1'b0;
`endif
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Observe n cycles of cpu_ce, returning first/last pulse cycle and count.
    task automatic watch(input int n, output int first, output int last, output int cnt);
        first = -1;
        last  = -1;
        cnt   = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.cpu_ce) begin
                if (first < 0) first = cyc;
                last = cyc;
                cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] mode, input logic [1:0] run_st, output int r);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.SW_mode = mode;
        repeat (5) @(posedge clk);
        #1;
        r = cyc;
        clear_sched(r);
        set_state(r, 2'b00);
        set_state(r + HOLD, run_st);
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the scheduled expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            mcount = 0;
            chk("reset_state", bus.ctrl_state, 0);
            chk("reset_ce", bus.cpu_ce, 0);
            chk("reset_cpu_rst_n", bus.cpu_rst_n, 0);
            chk("reset_count", bus.step_count, 0);
        end else if (cyc < N) begin
            chk("ctrl_state", bus.ctrl_state, exp_st[cyc]);
            chk("cpu_rst_n", bus.cpu_rst_n, (exp_st[cyc] != 2'b00) ? 1 : 0);
            chk("cpu_ce", bus.cpu_ce, exp_ce[cyc]);
            chk("step_count", bus.step_count, mcount % 65536);
`ifdef BREAKPOINT_EN
            chk("bp_hit", bus.bp_hit, exp_bp[cyc]);
`endif
            if (exp_ce[cyc]) mcount++;
        end
        if (w4_on && rst_w4 && cyc >= w4_base) begin
            chk("w4_ce", bus4.cpu_ce, 1);
            chk("w4_count", bus4.step_count, (cyc - w4_base) % 16);
        end
    end

    initial begin
        int r, p, s, first, last, n1, n2, rise;

        for (int i = 0; i < N; i++) begin
            exp_ce[i] = 1'b0;
            exp_st[i] = 2'b00;
`ifdef BREAKPOINT_EN
            exp_bp[i] = 1'b0;
`endif
        end
        bus.CLKButton  = 1'b0;
        bus.SW_mode    = 2'b00;
        bus.halt       = 1'b0;
        bus4.CLKButton = 1'b0;
        bus4.SW_mode   = 2'b10;
        bus4.halt      = 1'b0;
`ifdef BREAKPOINT_EN
        bus.pc        = 32'h0;
        bus.bp_addr   = 32'h0;
        bus.bp_valid  = 1'b0;
        bus4.pc       = 32'h0;
        bus4.bp_addr  = 32'h0;
        bus4.bp_valid = 1'b0;
`endif

        // Reset release in step mode, then a bouncing button press.
        do_reset(2'b00, 2'b01, r);
        rise = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cpu_rst_n && rise < 0) rise = cyc - r;
        end
        chk("hold_length", rise, 4);
        @(posedge clk);
        #1;
        wait_to(r + 12);
        for (int k = 0; k < 3; k++) begin
            bus.CLKButton = 1'b1;
            wait_to(cyc + 5);
            bus.CLKButton = 1'b0;
            wait_to(cyc + 5);
        end
        p = cyc;
        exp_ce[p + DEB + 3] = 1'b1;
        bus.CLKButton = 1'b1;
        watch(40, first, last, n1);
        chk("a_pulse_delay", first - p, 19);
        chk("a_pulses", n1, 1);
        bus.CLKButton = 1'b0;
        watch(30, first, last, n2);
        chk("a_count", bus.step_count, 1);

        // Slow run for 80 cycles after HOLD, then pause.
        do_reset(2'b01, 2'b10, r);
        for (int k = 0; k < 10; k++) exp_ce[r + HOLD + SLOW * (k + 1) - 1] = 1'b1;
        watch(84, first, last, n1);
        chk("b_first_pulse", first - r, 11);
        chk("b_pulse_span", last - first, 72);
        chk("b_pulses", n1, 10);
        s = cyc;
        set_state(s + 2, 2'b01);
        bus.SW_mode = 2'b11;
        watch(40, first, last, n2);
        chk("b_pause_pulses", n2, 0);
        chk("b_count", bus.step_count, 10);

        // Fast run; halt coincides with a divider terminal count.
        do_reset(2'b10, 2'b10, r);
        for (int k = 0; k < 2; k++) exp_ce[r + HOLD + FAST * (k + 1) - 1] = 1'b1;
        wait_to(r + 9);
        bus.halt = 1'b1;
        set_state(r + 10, 2'b11);
        wait_to(r + 10);
        bus.halt = 1'b0;
        bus.CLKButton = 1'b1;
        bus.SW_mode = 2'b00;
        watch(40, first, last, n1);
        bus.CLKButton = 1'b0;
        watch(60, first, last, n2);
        chk("c_pulses_after_halt", n1 + n2, 0);
        chk("c_state", bus.ctrl_state, 3);
        chk("c_count", bus.step_count, 2);

        // 4-bit counter wrap with FAST_DIV=1.
        @(posedge clk);
        #1;
        w4_base = cyc + HOLD;
        w4_on   = 1'b1;
        rst_w4  = 1'b1;
        wait_to(w4_base + 16);
        @(negedge clk);
        chk("d_wrap_zero", bus4.step_count, 0);
        @(negedge clk);
        chk("d_count_final", bus4.step_count, 1);
        @(posedge clk);
        #1;
        w4_on  = 1'b0;
        rst_w4 = 1'b0;

`ifdef BREAKPOINT_EN
        // Breakpoint during slow run, then a single step past it.
        do_reset(2'b01, 2'b10, r);
        bus.bp_addr  = 32'h0000000C;
        bus.bp_valid = 1'b1;
        for (int k = 0; k < 2; k++) exp_ce[r + HOLD + SLOW * (k + 1) - 1] = 1'b1;
        wait_to(r + 27);
        bus.pc = 32'h0000000C;
        set_state(r + 28, 2'b01);
        exp_bp[r + 28] = 1'b1;
        wait_to(r + 28);
        bus.pc = 32'h0;
        wait_to(r + 40);
        p = cyc;
        exp_ce[p + DEB + 3] = 1'b1;
        bus.CLKButton = 1'b1;
        watch(40, first, last, n1);
        chk("e_step_pulses", n1, 1);
        bus.CLKButton = 1'b0;
        watch(30, first, last, n2);
        chk("e_count", bus.step_count, 3);
        chk("e_state", bus.ctrl_state, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
